// File: rtl/debounce_edge.sv
// Switch/pin debouncer: synchronises din, qualifies a new level for DEBOUNCE_CYCLES
// cycles, then updates dout and pulses rise or fall for one cycle.
module debounce_edge #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic qbar,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic {STABLE, CHECKING} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q;
   logic [CNT_W-1:0]       cnt;
   state_t                 state;
   logic                   differ;
   logic                   accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_r <= '0;
      else     sync_r <= {sync_r[SYNC_STAGES-2:0], din};
   end

   assign sync_q = sync_r[SYNC_STAGES-1];
   assign differ = (sync_q != dout);
   // With a one-cycle window the first mismatch is accepted straight from STABLE.
   assign accept = differ && ((state == STABLE) ? (DEBOUNCE_CYCLES == 1) : (cnt == LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= STABLE;
         cnt   <= '0;
         dout  <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (accept) begin
            dout  <= sync_q;
            rise  <= sync_q;
            fall  <= ~sync_q;
            cnt   <= '0;
            state <= STABLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               STABLE: begin
                  if (differ) begin
                     state <= CHECKING;
                     busy  <= 1'b1;
                     cnt   <= CNT_W'(1);
                  end else begin
                     cnt <= '0;
                  end
               end
               CHECKING: begin
                  if (!differ) begin
                     state <= STABLE;
                     busy  <= 1'b0;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

   assign qbar = ~dout;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_debounce_edge;

   logic clk = 1'b0;
   logic rst, din;
   logic dout, qbar, rise, fall, busy;

   int total = 0;
   int bad   = 0;

   debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .din (din),
      .dout(dout),
      .qbar(qbar),
      .rise(rise),
      .fall(fall),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // exp = {dout, rise, fall, busy} after the edge
   typedef struct {
      logic       din;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[64];
   int   nvec = 0;

   task automatic add(input logic d, input logic [3:0] e);
      vecs[nvec].din = d;
      vecs[nvec].exp = e;
      nvec++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] e);
      logic [4:0] got, want;
      got  = {dout, qbar, rise, fall, busy};
      want = {e[3], ~e[3], e[2:0]};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got {dout,qbar,rise,fall,busy}=%b want %b", name, got, want);
      end
   endtask

   initial begin
      // clean rise
      add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(1, 4'b0001);
      add(1, 4'b0001); add(1, 4'b1100); add(1, 4'b1000); add(1, 4'b1000);
      // clean fall
      add(0, 4'b1000); add(0, 4'b1000); add(0, 4'b1001); add(0, 4'b1001);
      add(0, 4'b1001); add(0, 4'b0010); add(0, 4'b0000); add(0, 4'b0000);
      // 3-cycle glitch, rejected
      add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(0, 4'b0001);
      add(0, 4'b0001); add(0, 4'b0000); add(0, 4'b0000); add(0, 4'b0000);
      // bounce at cnt=3, then re-qualify from scratch
      add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(0, 4'b0001);
      add(1, 4'b0001); add(1, 4'b0000); add(1, 4'b0001); add(1, 4'b0001);
      add(1, 4'b0001); add(1, 4'b1100); add(1, 4'b1000);

      // reset before any clock edge
      rst = 1'b1;
      din = 1'b1;
      #1;
      check("reset_no_clk", 4'b0000);
      tick();
      check("reset_held", 4'b0000);
      din = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("after_release", 4'b0000);

      for (int i = 0; i < nvec; i++) begin
         din = vecs[i].din;
         tick();
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // reset while qualifying a fall with cnt=2
      din = 1'b0;
      tick(); check("mid_e1", 4'b1000);
      tick(); check("mid_e2", 4'b1000);
      tick(); check("mid_e3", 4'b1001);
      tick(); check("mid_e4", 4'b1001);
      rst = 1'b1;
      din = 1'b1;
      #1;
      check("mid_rst_async", 4'b0000);
      tick();
      check("mid_rst_held", 4'b0000);
      rst = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         check($sformatf("post_rst_e%0d", e),
               (e == 6) ? 4'b1100 : (e == 7) ? 4'b1000 :
               (e >= 3) ? 4'b0001 : 4'b0000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: sim time exceeded, bench did not complete");
      $fatal(1);
   end

endmodule
